// File: rtl/sram_port.sv
// sram_port: load/store front-end for a synchronous-read block SRAM.
// It accepts one byte, half or word request at a time. Stores become SRAM
// writes with byte strobes and lane-replicated data. Loads wait out the
// SRAM's one-cycle read latency, and the returned lane is then sign- or
// zero-extended. Every request ends in a response that is held until the
// client takes it. A misaligned or illegal-size request is answered with
// an error and never drives the SRAM.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_*                request channel (valid/ready): we, addr, wdata, size, unsigned
//   rsp_*                response channel (valid/ready): rdata, err
//   sram_*               SRAM write (wvalid/awaddr/wdata/wstrb) and read (araddr/rdata)
//
// state  | meaning
// S_IDLE | no request outstanding, ready for a new one
// S_RD   | load address sampled by SRAM, capturing/formatting read data
// S_RSP  | response valid and held until rsp_ready_i
module sram_port #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  sram_wvalid_o,
    output logic [ADDR_WIDTH-1:0] sram_awaddr_o,
    output logic [31:0]           sram_wdata_o,
    output logic [3:0]            sram_wstrb_o,
    output logic [ADDR_WIDTH-1:0] sram_araddr_o,
    input  logic [31:0]           sram_rdata_i
);

    if (DATA_WIDTH != 32) begin : g_drc
        $fatal(1, "sram_port: DATA_WIDTH must be 32");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_rsp_valid;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_unsigned;

    logic        w_err;
    logic        w_accept;
    logic [1:0]  w_off;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;

    assign w_off = req_addr_i[1:0];

    always_comb begin
        w_err = 1'b0;
        case (req_size_i)
            2'd0:    w_err = 1'b0;
            2'd1:    w_err = w_off[0];
            2'd2:    w_err = (w_off != 2'd0);
            default: w_err = 1'b1;
        endcase
    end

    // In S_RSP, readiness follows rsp_ready_i combinationally so a new
    // request can be taken in the same cycle the response is transferred.
    always_comb begin
        req_ready_o = 1'b0;
        if (rst_ni) begin
            case (r_state)
                S_IDLE:  req_ready_o = 1'b1;
                S_RSP:   req_ready_o = rsp_ready_i;
                default: req_ready_o = 1'b0;
            endcase
        end
    end

    assign w_accept = req_valid_i && req_ready_o;

    always_comb begin
        w_wdata = req_wdata_i;
        w_wstrb = 4'b1111;
        case (req_size_i)
            2'd0: begin
                w_wdata = {4{req_wdata_i[7:0]}};
                w_wstrb = 4'b0001 << w_off;
            end
            2'd1: begin
                w_wdata = {2{req_wdata_i[15:0]}};
                w_wstrb = 4'b0011 << w_off;
            end
            default: begin
                w_wdata = req_wdata_i;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    assign sram_wvalid_o = w_accept && req_we_i && !w_err;
    assign sram_awaddr_o = req_addr_i;
    assign sram_araddr_o = req_addr_i;
    assign sram_wdata_o  = w_wdata;
    assign sram_wstrb_o  = w_wstrb;

    function automatic logic [31:0] fmt_load(input logic [31:0] d,
                                             input logic [1:0]  off,
                                             input logic [1:0]  sz,
                                             input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = d[8*off +: 8];
        h = d[16*off[1] +: 16];
        case (sz)
            2'd0:    r = {{24{~uns & b[7]}}, b};
            2'd1:    r = {{16{~uns & h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
            r_off       <= 2'd0;
            r_size      <= 2'd0;
            r_unsigned  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_RSP: begin
                    if (w_accept) begin
                        r_off      <= w_off;
                        r_size     <= req_size_i;
                        r_unsigned <= req_unsigned_i;
                        if (!req_we_i && !w_err) begin
                            r_state     <= S_RD;
                            r_rsp_valid <= 1'b0;
                        end else begin
                            r_state     <= S_RSP;
                            r_rsp_valid <= 1'b1;
                            r_rdata     <= 32'd0;
                            r_err       <= w_err;
                        end
                    end else if (r_state == S_RSP && rsp_ready_i) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                S_RD: begin
                    r_rdata     <= fmt_load(sram_rdata_i, r_off, r_size, r_unsigned);
                    r_err       <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RSP;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;

endmodule
